if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 29 ++
 rtl/if_stage_if.sv | 29 ++
 rtl/if_stage_if_id_reg.sv | 72 +++++++
 rtl/if_stage.sv | 144 ++++++++++++++
 tb/tb_if_stage.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage_pkg
//  Description : Shared definitions for the instruction-fetch stage: fetch
//                FSM state encoding, reset-PC and bubble-instruction defaults,
//                and a word-alignment helper.
//  Revision    : 1.0  initial release
// ============================================================================
package if_stage_pkg;

  // REQ  : request outstanding (imem_req=1)
  // HOLD : word captured under freeze, waiting in the one-entry buffer
  // KILL : draining a request orphaned by a redirect
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    HOLD = 2'd1,
    KILL = 2'd2
  } fetch_state_e;

  localparam logic [31:0] C_RESET_PC  = 32'h0000_0000;
  // cond=NV, so decode squashes it
  localparam logic [31:0] C_NOP_INSTR = 32'hF000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage_if
//  Description : Instruction-memory read channel.
//                master : fetch stage (drives imem_req/imem_addr)
//                slave  : memory      (drives imem_ready/imem_rdata)
//  Revision    : 1.0  initial release
// ============================================================================
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/if_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : IF/ID pipeline register.
//                Priority: flush (bubble) > freeze (hold) > load (new word)
//                > otherwise bubble.
//  Ports       : clk, rst (sync, active-low)
//                load, freeze, flush        control
//                pc_in, instr_in            data to load (loaded as valid)
//                pc_out, instr_out, valid_out  register contents
//  Revision    : 1.0  initial release
// ============================================================================
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = C_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        freeze,
  input  logic        flush,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        valid_out
);

  logic [31:0] pc_d,    pc_q;
  logic [31:0] instr_d, instr_q;
  logic        valid_d, valid_q;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (flush) begin
      pc_d    = 32'd0;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (freeze) begin
      // hold
    end else if (load) begin
      pc_d    = pc_in;
      instr_d = instr_in;
      valid_d = 1'b1;
    end else begin
      pc_d    = 32'd0;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= 32'd0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_out    = pc_q;
  assign instr_out = instr_q;
  assign valid_out = valid_q;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : Instruction-fetch stage: PC, fetch FSM (REQ/HOLD/KILL),
//                one-entry freeze buffer, redirect register and IF/ID register.
//  Ports       : clk, rst (sync, active-low)
//                freeze                      hazard stall from decode
//                branch_taken, branch_addr   redirect from execute
//                imem (if_stage_if.master)   instruction-memory channel
//                pc_out, instr_out, valid_out  IF/ID outputs
//  Revision    : 1.0  initial release
// ============================================================================
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = C_RESET_PC,
  parameter logic [31:0] NOP_INSTR = C_NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [31:0]       branch_addr,
  if_stage_if.master        imem,
  output logic [31:0]       pc_out,
  output logic [31:0]       instr_out,
  output logic              valid_out
);

  fetch_state_e state_d, state_q;
  logic [31:0]  pc_d, pc_q;
  logic [31:0]  buf_pc_d, buf_pc_q;
  logic [31:0]  buf_instr_d, buf_instr_q;
  logic [31:0]  redir_d, redir_q;

  logic         ifid_load;
  logic [31:0]  ifid_pc;
  logic [31:0]  ifid_instr;
  logic [31:0]  pc_inc;
  logic [31:0]  target;

  assign pc_inc = pc_q + 32'd4;  // wraps modulo 2^32
  assign target = word_align(branch_addr);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    redir_d     = redir_q;
    ifid_load   = 1'b0;
    ifid_pc     = pc_inc;
    ifid_instr  = imem.imem_rdata;

    case (state_q)
      REQ: begin
        if (branch_taken) begin
          if (imem.imem_ready) begin
            pc_d = target;
          end else begin
            // request still in flight: remember where to go once it drains
            redir_d = target;
            state_d = KILL;
          end
        end else if (imem.imem_ready) begin
          pc_d = pc_inc;
          if (freeze) begin
            buf_pc_d    = pc_inc;
            buf_instr_d = imem.imem_rdata;
            state_d     = HOLD;
          end else begin
            ifid_load = 1'b1;
          end
        end
      end

      HOLD: begin
        if (branch_taken) begin
          pc_d    = target;
          state_d = REQ;
        end else if (!freeze) begin
          ifid_load  = 1'b1;
          ifid_pc    = buf_pc_q;
          ifid_instr = buf_instr_q;
          state_d    = REQ;
        end
      end

      KILL: begin
        // the returning word belongs to the abandoned path and is dropped
        if (branch_taken) begin
          if (imem.imem_ready) begin
            pc_d    = target;
            state_d = REQ;
          end else begin
            redir_d = target;
          end
        end else if (imem.imem_ready) begin
          pc_d    = redir_q;
          state_d = REQ;
        end
      end

      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      buf_pc_q    <= 32'd0;
      buf_instr_q <= 32'd0;
      redir_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
      redir_q     <= redir_d;
    end
  end

  // gated by rst so no request is ever presented while reset is applied
  assign imem.imem_req  = rst && (state_q != HOLD);
  assign imem.imem_addr = word_align(pc_q);

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .load      (ifid_load),
    .freeze    (freeze),
    .flush     (branch_taken),
    .pc_in     (ifid_pc),
    .instr_in  (ifid_instr),
    .pc_out    (pc_out),
    .instr_out (instr_out),
    .valid_out (valid_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_stage
//  Description : Self-checking bench for if_stage. A behavioural fetch model
//                (flags for "word parked" / "orphan in flight") predicts the
//                memory request and IF/ID contents every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_if_stage;

  localparam logic [31:0] C_NOP = 32'hF000_0000;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        valid_out;

  int checks = 0;
  int errors = 0;

  if_stage_if bus ();

  if_stage dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem         (bus.master),
    .pc_out       (pc_out),
    .instr_out    (instr_out),
    .valid_out    (valid_out)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [31:0] m_pc;
  logic        m_parked;      // a fetched word waits for decode to unfreeze
  logic [31:0] m_park_pc;
  logic [31:0] m_park_word;
  logic        m_orphan;      // a request from the abandoned path is in flight
  logic [31:0] m_target;
  logic [31:0] e_pc;
  logic [31:0] e_instr;
  logic        e_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic bubble();
    e_pc = 32'd0; e_instr = C_NOP; e_valid = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic f, input logic b,
                            input logic [31:0] ba, input logic rd);
    logic [31:0] tgt;
    tgt = {ba[31:2], 2'b00};
    if (!r) begin
      m_pc = 32'd0; m_parked = 1'b0; m_orphan = 1'b0;
      m_park_pc = 32'd0; m_park_word = 32'd0; m_target = 32'd0;
      bubble();
    end else if (b) begin
      bubble();
      if (m_parked) begin
        m_parked = 1'b0; m_pc = tgt;
      end else if (rd) begin
        m_orphan = 1'b0; m_pc = tgt;
      end else begin
        m_orphan = 1'b1; m_target = tgt;
      end
    end else if (m_parked) begin
      if (!f) begin
        e_pc = m_park_pc; e_instr = m_park_word; e_valid = 1'b1;
        m_parked = 1'b0;
      end
    end else if (m_orphan) begin
      if (!f) bubble();
      if (rd) begin
        m_orphan = 1'b0; m_pc = m_target;
      end
    end else if (rd) begin
      if (f) begin
        m_parked = 1'b1; m_park_pc = m_pc + 32'd4; m_park_word = mem_word(m_pc);
      end else begin
        e_pc = m_pc + 32'd4; e_instr = mem_word(m_pc); e_valid = 1'b1;
      end
      m_pc = m_pc + 32'd4;
    end else if (!f) begin
      bubble();
    end
  endtask

  // Called at a negedge; returns at the next negedge with IF/ID checked.
  task automatic step(input logic r, input logic f, input logic b,
                      input logic [31:0] ba, input logic rd);
    logic er;
    rst = r; freeze = f; branch_taken = b; branch_addr = ba;
    er = r && !m_parked;
    bus.imem_ready = rd && er;
    #1;
    check("imem_req", {31'd0, bus.imem_req}, {31'd0, er});
    if (er) check("imem_addr", bus.imem_addr, {m_pc[31:2], 2'b00});
    @(posedge clk);
    model_step(r, f, b, ba, rd && er);
    @(negedge clk);
    check("pc_out", pc_out, e_pc);
    check("instr_out", instr_out, e_instr);
    check("valid_out", {31'd0, valid_out}, {31'd0, e_valid});
  endtask

  logic [31:0] held_addr;

  initial begin
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0;
    bus.imem_ready = 1'b0;
    m_parked = 1'b0; m_orphan = 1'b0; m_pc = 32'd0;
    @(negedge clk);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // zero-wait fetch of three words
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0, 1);
      check("zw_pc", pc_out, 32'(4 * (k + 1)));
      check("zw_instr", instr_out, mem_word(32'(4 * k)));
    end

    // freeze while the word at 8 returns
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 1);
    check("frz_hold_pc", pc_out, 32'd8);
    step(1, 1, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    check("frz_rel_pc", pc_out, 32'd12);
    check("frz_rel_instr", instr_out, mem_word(32'd8));
    step(1, 0, 0, 0, 1);
    check("frz_next_instr", instr_out, mem_word(32'd12));

    // reset while parked in the buffer
    step(1, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_addr", bus.imem_addr, 32'd0);
    step(1, 0, 0, 0, 1);

    // branch together with freeze: flush wins
    step(1, 1, 1, 32'h0000_0043, 1);
    check("br_frz_valid", {31'd0, valid_out}, 32'd0);
    check("br_frz_instr", instr_out, C_NOP);
    check("br_frz_addr", bus.imem_addr, 32'h40);

    // branch with the request still outstanding, ready three cycles later
    step(1, 0, 1, 32'h0000_0200, 0);
    held_addr = bus.imem_addr;
    check("kill_addr_held", held_addr, 32'h40);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("kill_addr_held2", bus.imem_addr, held_addr);
    step(1, 0, 0, 0, 1);
    check("kill_drop_valid", {31'd0, valid_out}, 32'd0);
    check("kill_target", bus.imem_addr, 32'h200);

    // PC wrap
    step(1, 0, 1, 32'hFFFF_FFFC, 1);
    step(1, 0, 0, 0, 1);
    check("wrap_pc_out", pc_out, 32'd0);
    check("wrap_addr", bus.imem_addr, 32'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) != 0),
           ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 19) < 3),
           $urandom,
           ($urandom_range(0, 9) < 6));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
